mem_target_responder: RTL and testbench
=======================================

// Module: mem_target_responder
// PURPOSE
//  Bus-target end of the filtered memory request/response handshake: answers read and
//  write requests from an initiator (or from the overlap filter's forwarded path).
//  Decodes a fixed address window, backs it with a small register array, and inserts
//  programmable wait states. Out-of-window requests complete with an error flag.
//  Used as the downstream responder model and as a real scratch target in the eFPGA.
// PARAMETERS
//  ADDR_W       23         request address width
//  DATA_W       8          data width of wdata/rdata and of each storage word
//  DEPTH        16         number of storage words (power of 2)
//  BASE_ADDR    23'h203000 first word address of the decoded window
//  WAIT_CYCLES  2          wait states between address accept and data/response (1..15)
// PORTS
//  clk               in   1       clock, all logic on rising edge
//  reset             in   1       synchronous, active-low
//  req_addr_valid_i  in   1       initiator request valid; held until resp_addr_ready_o seen
//  rd_wr_i           in   1       0 = read, 1 = write; sampled with the address
//  addr_i            in   ADDR_W  request word address
//  req_w_valid_i     in   1       write data valid
//  wdata_i           in   DATA_W  write data, sampled when req_w_valid_i & resp_w_ready_o
//  req_r_b_ready_i   in   1       initiator accepts the read-data / write-response beat
//  resp_addr_ready_o out  1       one-cycle pulse: address accepted
//  resp_w_ready_o    out  1       target ready for write data
//  resp_r_b_valid_o  out  1       read data / write response valid
//  resp_rdata_o      out  DATA_W  read data, valid with resp_r_b_valid_o on reads
//  resp_err_o        out  1       valid with resp_r_b_valid_o: 1 = address outside window
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): all outputs 0, state IDLE, wait counter 0, all storage
//   words 0. Reset mid-transaction aborts it; no partial write lands; outputs 0 next cycle.
//  All outputs registered. Window hit: BASE_ADDR <= addr_i < BASE_ADDR+DEPTH, compared in
//   ADDR_W+1 bits (no wrap past 2^ADDR_W); index = (addr_i - BASE_ADDR)[log2(DEPTH)-1:0].
//  FSM states: IDLE, WAIT, WDATA, RESP.
//   IDLE : if req_addr_valid_i: latch addr_i, rd_wr_i, hit flag; resp_addr_ready_o<=1;
//          cnt<=WAIT_CYCLES-1; ->WAIT. Otherwise stay, all handshake outputs 0.
//   WAIT : resp_addr_ready_o<=0; if cnt!=0 cnt<=cnt-1, stay; if cnt==0:
//          read  -> resp_rdata_o<=hit?mem[idx]:0, resp_err_o<=!hit, resp_r_b_valid_o<=1, ->RESP
//          write -> resp_w_ready_o<=1, ->WDATA
//   WDATA: hold resp_w_ready_o=1 until req_w_valid_i=1; on that edge: if hit mem[idx]<=wdata_i
//          (miss: data discarded); resp_w_ready_o<=0; resp_err_o<=!hit; resp_r_b_valid_o<=1; ->RESP
//   RESP : hold resp_r_b_valid_o, resp_rdata_o, resp_err_o stable until req_r_b_ready_i=1;
//          on that edge clear valid, err, rdata to 0; ->IDLE. Next request accepted no
//          earlier than the following cycle (one idle cycle between transactions).
//  Latency (accept edge = E0): resp_addr_ready_o high in cycle E0+1 only; read
//   resp_r_b_valid_o rises at edge E0+WAIT_CYCLES; write resp_w_ready_o rises at the same edge.
//  req_addr_valid_i is ignored outside IDLE; held valid after the ready pulse does not
//   start a second transaction. rd_wr_i/addr_i changes after accept are ignored.
//  req_w_valid_i outside WDATA and req_r_b_ready_i outside RESP are ignored.
//  req_r_b_ready_i already high when valid rises: beat completes on the next edge
//   (valid high exactly one cycle).
//  Read of a word written in the immediately preceding transaction returns the new value.
// TESTING
//  1 reset=0 for 2 cycles -> all outputs 0; read of addr 23'h203005 returns rdata 8'h00, err 0.
//  2 write 8'hA5 to 23'h203003 (WAIT_CYCLES=2), then read it -> ready pulse 1 cycle after
//    accept, w_ready 2 cycles after accept, b_valid err=0; read returns 8'hA5, err 0.
//  3 read 23'h204000 (outside, DEPTH=16) -> rdata 8'h00, err 1; write 8'h5A to 23'h202FFF ->
//    err 1 and a subsequent read of 23'h203000..23'h20300F shows no word changed.
//  4 req_r_b_ready_i held 0 for 5 cycles in RESP -> r_b_valid, rdata, err stable 5 cycles;
//    ready=1 -> valid drops next edge, FSM IDLE; held req_addr_valid_i not re-accepted early.
//  5 back-to-back writes to 23'h20300F then 23'h203000 with w_valid delayed 3 cycles ->
//    w_ready held until w_valid; both words readable with correct values.
//  6 reset=0 asserted while in WDATA of a write to 23'h203001 -> outputs 0 next cycle,
//    later read of 23'h203001 returns 8'h00.

Source files
------------

// File: rtl/mem_target_responder.sv
// Bus-target responder: decodes a fixed word window backed by a small register array,
// inserts programmable wait states and flags out-of-window requests with an error.
module mem_target_responder #(
    parameter int                ADDR_W      = 23,
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 23'h203000,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_addr_valid_i,
    input  logic              rd_wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              req_w_valid_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              req_r_b_ready_i,
    output logic              resp_addr_ready_o,
    output logic              resp_w_ready_o,
    output logic              resp_r_b_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [1:0]        dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    // Handshake: the address channel is a one-cycle accept pulse while the initiator
    // holds valid; w and r/b channels complete on the edge where valid & ready are both 1.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WDATA = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_rd_wr;
    logic                w_rd_wr_nxt;
    logic                r_hit;
    logic                w_hit_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                r_addr_ready;
    logic                w_addr_ready_nxt;
    logic                r_w_ready;
    logic                w_w_ready_nxt;
    logic                r_rb_valid;
    logic                w_rb_valid_nxt;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                w_mem_we;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [ADDR_W:0]     w_addr_ext;
    logic [ADDR_W:0]     w_base_ext;
    logic [ADDR_W:0]     w_top_ext;
    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;

    // One extra bit so a window ending at 2^ADDR_W cannot wrap back to zero.
    assign w_addr_ext = {1'b0, addr_i};
    assign w_base_ext = {1'b0, BASE_ADDR};
    assign w_top_ext  = w_base_ext + (ADDR_W+1)'(DEPTH);
    assign w_hit      = (w_addr_ext >= w_base_ext) && (w_addr_ext < w_top_ext);
    assign w_idx      = addr_i[IDX_W-1:0] - BASE_ADDR[IDX_W-1:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_rd_wr_nxt      = r_rd_wr;
        w_hit_nxt        = r_hit;
        w_idx_nxt        = r_idx;
        w_addr_ready_nxt = 1'b0;
        w_w_ready_nxt    = r_w_ready;
        w_rb_valid_nxt   = r_rb_valid;
        w_rdata_nxt      = r_rdata;
        w_err_nxt        = r_err;
        w_mem_we         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_addr_valid_i) begin
                    w_rd_wr_nxt      = rd_wr_i;
                    w_hit_nxt        = w_hit;
                    w_idx_nxt        = w_idx;
                    w_addr_ready_nxt = 1'b1;
                    w_cnt_nxt        = CNT_W'(WAIT_CYCLES - 1);
                    w_state_nxt      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!r_rd_wr) begin
                    w_rdata_nxt    = r_hit ? r_mem[r_idx] : '0;
                    w_err_nxt      = !r_hit;
                    w_rb_valid_nxt = 1'b1;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_w_ready_nxt = 1'b1;
                    w_state_nxt   = S_WDATA;
                end
            end
            S_WDATA: begin
                if (req_w_valid_i) begin
                    w_mem_we       = r_hit;
                    w_w_ready_nxt  = 1'b0;
                    w_err_nxt      = !r_hit;
                    w_rb_valid_nxt = 1'b1;
                    w_state_nxt    = S_RESP;
                end
            end
            S_RESP: begin
                if (req_r_b_ready_i) begin
                    w_rb_valid_nxt = 1'b0;
                    w_err_nxt      = 1'b0;
                    w_rdata_nxt    = '0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rd_wr      <= 1'b0;
            r_hit        <= 1'b0;
            r_idx        <= '0;
            r_addr_ready <= 1'b0;
            r_w_ready    <= 1'b0;
            r_rb_valid   <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rd_wr      <= w_rd_wr_nxt;
            r_hit        <= w_hit_nxt;
            r_idx        <= w_idx_nxt;
            r_addr_ready <= w_addr_ready_nxt;
            r_w_ready    <= w_w_ready_nxt;
            r_rb_valid   <= w_rb_valid_nxt;
            r_rdata      <= w_rdata_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[r_idx] <= wdata_i;
        end
    end

    assign resp_addr_ready_o = r_addr_ready;
    assign resp_w_ready_o    = r_w_ready;
    assign resp_r_b_valid_o  = r_rb_valid;
    assign resp_rdata_o      = r_rdata;
    assign resp_err_o        = r_err;
    assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_mem_target_responder.sv
// Directed bench for mem_target_responder: reset, window decode, wait-state latency,
// response hold, delayed write data and reset during a write.
module tb_mem_target_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_addr_valid_i = 1'b0;
    logic        rd_wr_i = 1'b0;
    logic [22:0] addr_i = '0;
    logic        req_w_valid_i = 1'b0;
    logic [7:0]  wdata_i = '0;
    logic        req_r_b_ready_i = 1'b0;
    logic        resp_addr_ready_o;
    logic        resp_w_ready_o;
    logic        resp_r_b_valid_o;
    logic [7:0]  resp_rdata_o;
    logic        resp_err_o;
    logic [1:0]  dbg_state_o;

    int n_pass = 0;
    int n_total = 0;

    mem_target_responder dut (
        .clk               (clk),
        .reset             (reset),
        .req_addr_valid_i  (req_addr_valid_i),
        .rd_wr_i           (rd_wr_i),
        .addr_i            (addr_i),
        .req_w_valid_i     (req_w_valid_i),
        .wdata_i           (wdata_i),
        .req_r_b_ready_i   (req_r_b_ready_i),
        .resp_addr_ready_o (resp_addr_ready_o),
        .resp_w_ready_o    (resp_w_ready_o),
        .resp_r_b_valid_o  (resp_r_b_valid_o),
        .resp_rdata_o      (resp_rdata_o),
        .resp_err_o        (resp_err_o),
        .dbg_state_o       (dbg_state_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_addr_ready_o) break;
        end
        if (!resp_addr_ready_o) begin
            n_total++;
            $display("FAIL %s_addr_ready timeout: got 0, need 1", name);
        end
        req_addr_valid_i = 1'b0;
    endtask

    task automatic wait_sig(input string name, input int which);
        for (int i = 0; i < 40; i++) begin
            if ((which == 0 && resp_w_ready_o) || (which == 1 && resp_r_b_valid_o)) break;
            tick();
        end
        if (!((which == 0 && resp_w_ready_o) || (which == 1 && resp_r_b_valid_o))) begin
            n_total++;
            $display("FAIL %s_wait timeout: got 0, need 1", name);
        end
    endtask

    task automatic do_read(input logic [22:0] a, output logic [7:0] rd, output logic e);
        req_addr_valid_i = 1'b1;
        rd_wr_i = 1'b0;
        addr_i = a;
        wait_ready("rd");
        wait_sig("rd_valid", 1);
        rd = resp_rdata_o;
        e = resp_err_o;
        req_r_b_ready_i = 1'b1;
        tick();
        req_r_b_ready_i = 1'b0;
    endtask

    task automatic do_write(input logic [22:0] a, input logic [7:0] d, output logic e);
        req_addr_valid_i = 1'b1;
        rd_wr_i = 1'b1;
        addr_i = a;
        wait_ready("wr");
        wait_sig("wr_wready", 0);
        req_w_valid_i = 1'b1;
        wdata_i = d;
        tick();
        req_w_valid_i = 1'b0;
        wait_sig("wr_bvalid", 1);
        e = resp_err_o;
        req_r_b_ready_i = 1'b1;
        tick();
        req_r_b_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic e;
        reset = 1'b0;
        tick();
        tick();
        n_total++;
        if ({resp_addr_ready_o, resp_w_ready_o, resp_r_b_valid_o, resp_rdata_o, resp_err_o} !== 12'h000)
            $display("FAIL reset_outputs: got %b %b %b %h %b, need all 0", resp_addr_ready_o,
                     resp_w_ready_o, resp_r_b_valid_o, resp_rdata_o, resp_err_o);
        else n_pass++;
        n_total++;
        if (dbg_state_o !== 2'd0) $display("FAIL reset_state: got %0d, need 0", dbg_state_o);
        else n_pass++;
        reset = 1'b1;
        tick();
        do_read(23'h203005, rd, e);
        n_total++;
        if (rd !== 8'h00 || e !== 1'b0) $display("FAIL reset_read: got %h err %b, need 00 err 0", rd, e);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [7:0] rd;
        logic e;
        req_addr_valid_i = 1'b1;
        rd_wr_i = 1'b1;
        addr_i = 23'h203003;
        tick();
        req_addr_valid_i = 1'b0;
        n_total++;
        if (resp_addr_ready_o !== 1'b1 || resp_w_ready_o !== 1'b0)
            $display("FAIL wr_lat_e1: got ardy %b wrdy %b, need 1 0", resp_addr_ready_o, resp_w_ready_o);
        else n_pass++;
        tick();
        n_total++;
        if (resp_addr_ready_o !== 1'b0 || resp_w_ready_o !== 1'b0)
            $display("FAIL wr_lat_e2: got ardy %b wrdy %b, need 0 0", resp_addr_ready_o, resp_w_ready_o);
        else n_pass++;
        tick();
        n_total++;
        if (resp_w_ready_o !== 1'b1) $display("FAIL wr_lat_wready: got %b, need 1", resp_w_ready_o);
        else n_pass++;
        req_w_valid_i = 1'b1;
        wdata_i = 8'hA5;
        tick();
        req_w_valid_i = 1'b0;
        n_total++;
        if (resp_r_b_valid_o !== 1'b1 || resp_err_o !== 1'b0 || resp_w_ready_o !== 1'b0)
            $display("FAIL wr_bresp: got valid %b err %b wrdy %b, need 1 0 0",
                     resp_r_b_valid_o, resp_err_o, resp_w_ready_o);
        else n_pass++;
        req_r_b_ready_i = 1'b1;
        tick();
        req_r_b_ready_i = 1'b0;
        n_total++;
        if (resp_r_b_valid_o !== 1'b0) $display("FAIL wr_bdrop: got %b, need 0", resp_r_b_valid_o);
        else n_pass++;
        do_read(23'h203003, rd, e);
        n_total++;
        if (rd !== 8'hA5 || e !== 1'b0) $display("FAIL rd_back: got %h err %b, need a5 err 0", rd, e);
        else n_pass++;
    endtask

    task automatic test_out_of_window();
        logic [7:0] rd;
        logic e;
        logic [7:0] exp_v;
        do_read(23'h204000, rd, e);
        n_total++;
        if (rd !== 8'h00 || e !== 1'b1) $display("FAIL oow_read: got %h err %b, need 00 err 1", rd, e);
        else n_pass++;
        do_write(23'h202FFF, 8'h5A, e);
        n_total++;
        if (e !== 1'b1) $display("FAIL oow_write_err: got %b, need 1", e);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            exp_v = (i == 3) ? 8'hA5 : 8'h00;
            do_read(23'h203000 + 23'(i), rd, e);
            n_total++;
            if (rd !== exp_v || e !== 1'b0)
                $display("FAIL oow_scan[%0d]: got %h err %b, need %h err 0", i, rd, e, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_resp_hold();
        req_addr_valid_i = 1'b1;
        rd_wr_i = 1'b0;
        addr_i = 23'h203003;
        tick();
        tick();
        tick();
        n_total++;
        if (resp_r_b_valid_o !== 1'b1 || resp_rdata_o !== 8'hA5)
            $display("FAIL hold_rise: got valid %b data %h, need 1 a5", resp_r_b_valid_o, resp_rdata_o);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (resp_r_b_valid_o !== 1'b1 || resp_rdata_o !== 8'hA5 || resp_err_o !== 1'b0 ||
                resp_addr_ready_o !== 1'b0)
                $display("FAIL hold_cyc%0d: got valid %b data %h err %b ardy %b, need 1 a5 0 0",
                         i, resp_r_b_valid_o, resp_rdata_o, resp_err_o, resp_addr_ready_o);
            else n_pass++;
        end
        req_r_b_ready_i = 1'b1;
        tick();
        req_r_b_ready_i = 1'b0;
        n_total++;
        if (resp_r_b_valid_o !== 1'b0 || dbg_state_o !== 2'd0 || resp_addr_ready_o !== 1'b0 ||
            resp_rdata_o !== 8'h00)
            $display("FAIL hold_release: got valid %b state %0d ardy %b data %h, need 0 0 0 00",
                     resp_r_b_valid_o, dbg_state_o, resp_addr_ready_o, resp_rdata_o);
        else n_pass++;
        req_addr_valid_i = 1'b0;
        tick();
        n_total++;
        if (dbg_state_o !== 2'd0 || resp_addr_ready_o !== 1'b0)
            $display("FAIL hold_idle: got state %0d ardy %b, need 0 0", dbg_state_o, resp_addr_ready_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [22:0] addrs [2];
        logic [7:0]  datas [2];
        logic [7:0]  rd;
        logic        e;
        addrs[0] = 23'h20300F; datas[0] = 8'h3C;
        addrs[1] = 23'h203000; datas[1] = 8'hC3;
        for (int t = 0; t < 2; t++) begin
            req_addr_valid_i = 1'b1;
            rd_wr_i = 1'b1;
            addr_i = addrs[t];
            wait_ready("b2b");
            wait_sig("b2b_wready", 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                n_total++;
                if (resp_w_ready_o !== 1'b1 || resp_r_b_valid_o !== 1'b0)
                    $display("FAIL b2b_wait%0d_%0d: got wrdy %b valid %b, need 1 0",
                             t, i, resp_w_ready_o, resp_r_b_valid_o);
                else n_pass++;
            end
            req_w_valid_i = 1'b1;
            wdata_i = datas[t];
            tick();
            req_w_valid_i = 1'b0;
            n_total++;
            if (resp_r_b_valid_o !== 1'b1 || resp_err_o !== 1'b0 || resp_w_ready_o !== 1'b0)
                $display("FAIL b2b_resp%0d: got valid %b err %b wrdy %b, need 1 0 0",
                         t, resp_r_b_valid_o, resp_err_o, resp_w_ready_o);
            else n_pass++;
            req_r_b_ready_i = 1'b1;
            tick();
            req_r_b_ready_i = 1'b0;
        end
        for (int t = 0; t < 2; t++) begin
            do_read(addrs[t], rd, e);
            n_total++;
            if (rd !== datas[t] || e !== 1'b0)
                $display("FAIL b2b_read%0d: got %h err %b, need %h err 0", t, rd, e, datas[t]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        logic e;
        req_addr_valid_i = 1'b1;
        rd_wr_i = 1'b1;
        addr_i = 23'h203001;
        wait_ready("rst_mid");
        wait_sig("rst_mid_wready", 0);
        n_total++;
        if (dbg_state_o !== 2'd2) $display("FAIL rst_mid_in_wdata: got %0d, need 2", dbg_state_o);
        else n_pass++;
        req_w_valid_i = 1'b1;
        wdata_i = 8'h77;
        reset = 1'b0;
        tick();
        req_w_valid_i = 1'b0;
        n_total++;
        if ({resp_addr_ready_o, resp_w_ready_o, resp_r_b_valid_o, resp_rdata_o, resp_err_o} !== 12'h000 ||
            dbg_state_o !== 2'd0)
            $display("FAIL rst_mid_outputs: got %b %b %b %h %b state %0d, need all 0", resp_addr_ready_o,
                     resp_w_ready_o, resp_r_b_valid_o, resp_rdata_o, resp_err_o, dbg_state_o);
        else n_pass++;
        reset = 1'b1;
        tick();
        do_read(23'h203001, rd, e);
        n_total++;
        if (rd !== 8'h00 || e !== 1'b0) $display("FAIL rst_mid_read: got %h err %b, need 00 err 0", rd, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_window();
        test_resp_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
